// File: rtl/fifo_fwft_flagged.sv
// First-word-fall-through FIFO with occupancy, almost/full/empty flags and
// sticky overflow/underflow error flags; all DEPTH entries usable.
// Ports: clk, srst (async, active-high), wr_en/din/full/almost_full,
//   rd_en/dout/empty/almost_empty, level, overflow/underflow, clr_err.
// Option: define FIFO_FWFT_FLAGGED_REG_OUT_EN to drive dout from an output flop.
module fifo_fwft_flagged #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 4,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [AW-1:0] PONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [LW-1:0]    cnt;
    logic             wr_ok;
    logic             rd_ok;

    // Flags decode from the registered count only, so a same-cycle pop
    // never frees room for a write and a write never bypasses to a reader.
    assign full         = (cnt == DEPTH_L);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AF_L);
    assign almost_empty = (cnt <= AE_L);
    assign level        = cnt;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[tail] <= din;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                tail <= tail + PONE;
            end
            if (rd_ok) begin
                head <= head + PONE;
            end
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + ONE_L;
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - ONE_L;
            end
            // A new error event wins over a coincident clear.
            overflow  <= (wr_en && full) || (overflow && !clr_err);
            underflow <= (rd_en && empty) || (underflow && !clr_err);
        end
    end

`ifdef FIFO_FWFT_FLAGGED_REG_OUT_EN
    logic [WIDTH-1:0] dout_q;
    logic [AW-1:0]    head_nxt;

    assign head_nxt = head + PONE;

    // The flop mirrors the head entry. With one entry left and a
    // simultaneous write, the successor is still in flight on din.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            dout_q <= '0;
        end else if (wr_ok && empty) begin
            dout_q <= din;
        end else if (rd_ok) begin
            if (cnt > ONE_L) begin
                dout_q <= mem[head_nxt];
            end else if (wr_ok) begin
                dout_q <= din;
            end
        end
    end

    assign dout = dout_q;
`else
    assign dout = mem[head];
`endif

endmodule

// File: tb/tb_fifo_fwft_flagged.sv
// Self-checking bench for fifo_fwft_flagged (DEPTH=16, WIDTH=4, AF=14, AE=1).
// Queue scoreboard for data order plus a level/flag model checked each cycle.
module tb_fifo_fwft_flagged;
    logic       clk;
    logic       srst;
    logic       wr_en;
    logic [3:0] din;
    logic       full;
    logic       almost_full;
    logic       rd_en;
    logic [3:0] dout;
    logic       empty;
    logic       almost_empty;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] sb[$];
    int         mlevel = 0;
    logic       mov = 1'b0;
    logic       mud = 1'b0;

    fifo_fwft_flagged #(
        .DEPTH(16), .WIDTH(4), .AF_THRESH(14), .AE_THRESH(1)
    ) dut (
        .clk(clk), .srst(srst),
        .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; pops the scoreboard when a read is accepted
    // and checks level and flags against the model after the edge.
    task automatic cyc(input logic w, input logic [3:0] d,
                       input logic r, input logic c);
        logic       wok;
        logic       rok;
        logic [3:0] e;
        logic [5:0] fexp;
        wr_en = w; din = d; rd_en = r; clr_err = c;
        wok = w && (mlevel != 16);
        rok = r && (mlevel != 0);
        if (rok) begin
            e = sb.pop_front();
            checks++;
            if (dout !== e) begin
                failures++;
                $display("FAIL dout_order got=%h exp=%h", dout, e);
            end
        end
        if (wok) sb.push_back(d);
        mov = (w && mlevel == 16) || (mov && !c);
        mud = (r && mlevel == 0) || (mud && !c);
        if (wok && !rok) mlevel++;
        else if (rok && !wok) mlevel--;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        checks++;
        if (level !== 5'(mlevel)) begin
            failures++;
            $display("FAIL level got=%0d exp=%0d", level, mlevel);
        end
        fexp = {mlevel == 16, mlevel == 0, mlevel >= 14, mlevel <= 1, mov, mud};
        checks++;
        if ({full, empty, almost_full, almost_empty, overflow, underflow} !== fexp) begin
            failures++;
            $display("FAIL flags got=%b exp=%b",
                     {full, empty, almost_full, almost_empty, overflow, underflow}, fexp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mlevel = 0;
        mov = 1'b0;
        mud = 1'b0;
    endtask

    task automatic test_reset();
        cyc(0, 4'h0, 1, 0);
        cyc(1, 4'h1, 0, 0);
        cyc(1, 4'h2, 0, 0);
        cyc(1, 4'h3, 0, 0);
        #3 srst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000
            || level !== 5'd0) begin
            failures++;
            $display("FAIL async_reset got=%b lvl=%0d exp=110000 lvl=0",
                     {empty, almost_empty, full, almost_full, overflow, underflow}, level);
        end
`ifdef FIFO_FWFT_FLAGGED_REG_OUT_EN
        checks++;
        if (dout !== 4'h0) begin
            failures++;
            $display("FAIL reset_dout got=%h exp=0", dout);
        end
`endif
        @(posedge clk);
        #1 srst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 4'(i), 0, 0);
            checks++;
            if (almost_full !== (i + 1 >= 14)) begin
                failures++;
                $display("FAIL almost_full lvl=%0d got=%b", i + 1, almost_full);
            end
        end
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL full_at_16 got=%b exp=1", full);
        end
        cyc(1, 4'h7, 0, 0);
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            failures++;
            $display("FAIL overflow_17th got=%b lvl=%0d exp=1 lvl=16", overflow, level);
        end
        for (int i = 0; i < 16; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) cyc(1, 4'(i + 9), 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 4'($urandom_range(0, 15)), 1, 0);
        checks++;
        if (level !== 5'd5) begin
            failures++;
            $display("FAIL simul_level got=%0d exp=5", level);
        end
        for (int i = 0; i < 11; i++) cyc(1, 4'(15 - i), 0, 0);
        cyc(1, 4'h5, 1, 0);
        checks++;
        if (level !== 5'd15 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL full_wr_rd got=%0d/%b exp=15/1", level, overflow);
        end
        for (int i = 0; i < 15; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 1);
        cyc(1, 4'hC, 1, 0);
        checks++;
        if (level !== 5'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL empty_wr_rd got=%0d/%b exp=1/1", level, underflow);
        end
        cyc(0, 4'h0, 1, 1);
    endtask

    task automatic test_fwft_latency();
        cyc(1, 4'hA, 0, 0);
        checks++;
        if (empty !== 1'b0 || dout !== 4'hA) begin
            failures++;
            $display("FAIL fwft got=%b/%h exp=0/a", empty, dout);
        end
        cyc(0, 4'h0, 1, 0);
        checks++;
        if (empty !== 1'b1 || level !== 5'd0) begin
            failures++;
            $display("FAIL pop_empty got=%b/%0d exp=1/0", empty, level);
        end
`ifdef FIFO_FWFT_FLAGGED_REG_OUT_EN
        checks++;
        if (dout !== 4'hA) begin
            failures++;
            $display("FAIL dout_hold got=%h exp=a", dout);
        end
`endif
    endtask

    task automatic test_error_clear();
        cyc(0, 4'h0, 1, 0);
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set got=%b exp=1", underflow);
        end
        cyc(0, 4'h0, 0, 1);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_err got=%b exp=0", underflow);
        end
        cyc(0, 4'h0, 1, 1);
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL set_wins got=%b exp=1", underflow);
        end
        cyc(0, 4'h0, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) cyc(1, 4'(i + 4), 0, 0);
        checks++;
        if (level !== 5'd9) begin
            failures++;
            $display("FAIL pre_reset_level got=%0d exp=9", level);
        end
        #3 srst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (level !== 5'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got=%0d/%b exp=0/1", level, empty);
        end
        @(posedge clk);
        #1 srst = 1'b0;
        cyc(1, 4'h3, 0, 0);
        checks++;
        if (dout !== 4'h3 || level !== 5'd1) begin
            failures++;
            $display("FAIL no_stale got=%h/%0d exp=3/1", dout, level);
        end
        cyc(0, 4'h0, 1, 0);
    endtask

    initial begin
        srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 4'h0;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        test_reset();
        test_fill();
        test_simultaneous();
        test_fwft_latency();
        test_error_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
